data_cache_refill_ctrl: RTL and testbench



---
 rtl/data_cache_refill_ctrl_pkg.sv | 27 ++
 rtl/data_cache_refill_ctrl_if.sv | 31 +++
 rtl/data_cache_refill_ctrl.sv | 134 +++++++++++++
 tb/tb_data_cache_refill_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_refill_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_cache_refill_ctrl_pkg                                         |
// | Shared state encoding, memory-op encoding and qword geometry for   |
// | the data-cache refill sequencer.                                   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package data_cache_refill_ctrl_pkg;

   // Sequencer states, plain constants so legacy tools see fixed codes
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_CHK  = 3'd2;
   localparam logic [2:0] S_WB   = 3'd3;
   localparam logic [2:0] S_RF   = 3'd4;
   localparam logic [2:0] S_UPD  = 3'd5;
   localparam logic [2:0] S_DONE = 3'd6;

   // Value driven on mem_we_o for each kind of memory request
   localparam logic MEM_OP_WB = 1'b1;
   localparam logic MEM_OP_RF = 1'b0;

   // One qword is four 32-bit words
   localparam int QWORD_BYTES = 16;

endpackage
`default_nettype wire

// File: rtl/data_cache_refill_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_cache_refill_ctrl_if                                          |
// | Memory master bus of the refill sequencer: 128-bit req/ack port.   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface data_cache_refill_ctrl_if #(
   parameter int MEM_ADDR_WIDTH = 32
) ();

   logic                      mem_req_o;
   logic                      mem_we_o;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
   logic [127:0]              mem_wdata_o;
   logic [127:0]              mem_rdata_i;
   logic                      mem_ack_i;

   // Sequencer side issues requests
   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i, mem_ack_i
   );

   // Memory side answers them
   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i, mem_ack_i
   );

endinterface
`default_nettype wire

// File: rtl/data_cache_refill_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_cache_refill_ctrl                                             |
// | Walks every qword of one cache block: writes back dirty qwords,    |
// | refetches each qword from memory and loads it into the block.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module data_cache_refill_ctrl
   import data_cache_refill_ctrl_pkg::*;
#(
   parameter  int ADDR_WIDTH     = 5,
   parameter  int MEM_ADDR_WIDTH = 32,
   localparam int QWORD_COUNT    = 2 ** (ADDR_WIDTH - 2)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic [MEM_ADDR_WIDTH-1:0] base_addr_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [ADDR_WIDTH-3:0]     cache_addr_r_o,
   input  logic [31:0]               cache_data0_i,
   input  logic [31:0]               cache_data1_i,
   input  logic [31:0]               cache_data2_i,
   input  logic [31:0]               cache_data3_i,
   input  logic [QWORD_COUNT-1:0]    dirty_i,
   output logic [127:0]              flush_data_o,
   output logic [QWORD_COUNT-1:0]    flushing_n_o,
   output logic                      cleaned_n_o,
   data_cache_refill_ctrl_if.master  mem
);

   localparam int                      IDX_PAD    = MEM_ADDR_WIDTH - (ADDR_WIDTH - 2);
   localparam logic [ADDR_WIDTH-3:0]   LAST_IDX   = '1;
   localparam logic [QWORD_COUNT-1:0]  STROBE_ONE = QWORD_COUNT'(1);
   localparam logic [MEM_ADDR_WIDTH-1:0] QW_BYTES = MEM_ADDR_WIDTH'(QWORD_BYTES);

   logic [2:0]                state;
   logic [ADDR_WIDTH-3:0]     idx;
   logic [MEM_ADDR_WIDTH-1:0] base;
   logic                      req;
   logic                      we;
   logic [127:0]              wdata;
   logic [127:0]              fdata;

   // Sequencer FSM and datapath registers; reset aborts any transfer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         idx   <= '0;
         base  <= '0;
         req   <= 1'b0;
         we    <= MEM_OP_RF;
         wdata <= '0;
         fdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  // Blocks are qword aligned, low address bits are dropped
                  base  <= base_addr_i & ~(QW_BYTES - MEM_ADDR_WIDTH'(1));
                  idx   <= '0;
                  state <= S_RD;
               end
            end
            S_RD: begin
               // Block read port is registered: data shows up next cycle
               state <= S_CHK;
            end
            S_CHK: begin
               wdata <= {cache_data3_i, cache_data2_i, cache_data1_i, cache_data0_i};
               req   <= 1'b1;
               if (dirty_i[idx]) begin
                  we    <= MEM_OP_WB;
                  state <= S_WB;
               end else begin
                  we    <= MEM_OP_RF;
                  state <= S_RF;
               end
            end
            S_WB: begin
               // Refill read follows the write-back with req kept high
               if (mem.mem_ack_i) begin
                  we    <= MEM_OP_RF;
                  state <= S_RF;
               end
            end
            S_RF: begin
               if (mem.mem_ack_i) begin
                  fdata <= mem.mem_rdata_i;
                  req   <= 1'b0;
                  state <= S_UPD;
               end
            end
            S_UPD: begin
               if (idx == LAST_IDX) begin
                  state <= S_DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= S_RD;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Status and block-update outputs decoded from the current state
   always_comb begin
      busy_o       = (state != S_IDLE) && (state != S_DONE);
      done_o       = (state == S_DONE);
      flushing_n_o = '1;
      cleaned_n_o  = 1'b1;
      if (state == S_UPD) begin
         flushing_n_o = ~(STROBE_ONE << idx);
         cleaned_n_o  = 1'b0;
      end
   end

   assign cache_addr_r_o  = idx;
   assign flush_data_o    = fdata;
   assign mem.mem_req_o   = req;
   assign mem.mem_we_o    = we;
   assign mem.mem_wdata_o = wdata;
   // Address wraps at MEM_ADDR_WIDTH by construction of the sum
   assign mem.mem_addr_o  = base + ({{IDX_PAD{1'b0}}, idx} * QW_BYTES);

endmodule
`default_nettype wire

// File: tb/tb_data_cache_refill_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_data_cache_refill_ctrl                                          |
// | Directed, table-driven bench for the refill sequencer with a       |
// | registered cache-block model and a delayed-ack memory model.       |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_data_cache_refill_ctrl;

   typedef struct {
      logic         we;
      logic [31:0]  addr;
      logic [127:0] data;
   } txn_t;

   typedef struct {
      logic [7:0]   fl;
      logic [127:0] data;
      logic         cl;
   } upd_t;

   typedef struct {
      logic [7:0]  dirty;
      logic [31:0] base;
      int          delay;
      int          exp_cycles;
      int          exp_writes;
   } vec_t;

   logic         clk;
   logic         rst;
   logic         start;
   logic [31:0]  base_addr;
   logic         busy;
   logic         done;
   logic [2:0]   cache_addr;
   logic [31:0]  cd0, cd1, cd2, cd3;
   logic [7:0]   dirty;
   logic [127:0] flush_data;
   logic [7:0]   flushing_n;
   logic         cleaned_n;

   int n_tests = 0;
   int n_fail  = 0;
   int ack_delay = 0;
   int wait_cnt  = 0;
   int stab_err  = 0;

   txn_t wq[$];
   txn_t rq[$];
   upd_t fq[$];
   vec_t vecs[6];

   data_cache_refill_ctrl_if #(.MEM_ADDR_WIDTH(32)) mem_bus ();

   data_cache_refill_ctrl #(
      .ADDR_WIDTH     (5),
      .MEM_ADDR_WIDTH (32)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .base_addr_i    (base_addr),
      .busy_o         (busy),
      .done_o         (done),
      .cache_addr_r_o (cache_addr),
      .cache_data0_i  (cd0),
      .cache_data1_i  (cd1),
      .cache_data2_i  (cd2),
      .cache_data3_i  (cd3),
      .dirty_i        (dirty),
      .flush_data_o   (flush_data),
      .flushing_n_o   (flushing_n),
      .cleaned_n_o    (cleaned_n),
      .mem            (mem_bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cache word k of qword q; qword 2 holds 0x11,0x22,0x33,0x44
   function automatic logic [31:0] cword(input int q, input int k);
      logic [31:0] r;
      r = 32'(q ^ 2) << 16;
      r = r | 32'(17 * (k + 1));
      return r;
   endfunction

   // Memory read data as a function of the byte address
   function automatic logic [127:0] rd_pattern(input logic [31:0] a);
      return {a ^ 32'hDEAD_BEEF, ~a, a + 32'h1111_1111, a};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Cache block model, memory responder and monitors, all on the falling edge
   initial begin : model
      logic         prev_req, prev_ack, prev_we;
      logic [31:0]  prev_addr;
      logic [127:0] prev_wdata;
      prev_req = 1'b0; prev_ack = 1'b0; prev_we = 1'b0;
      prev_addr = '0; prev_wdata = '0;
      mem_bus.mem_ack_i   = 1'b0;
      mem_bus.mem_rdata_i = '0;
      cd0 = '0; cd1 = '0; cd2 = '0; cd3 = '0;
      forever begin
         @(negedge clk);
         cd0 = cword(int'(cache_addr), 0);
         cd1 = cword(int'(cache_addr), 1);
         cd2 = cword(int'(cache_addr), 2);
         cd3 = cword(int'(cache_addr), 3);
         if (flushing_n !== 8'hFF)
            fq.push_back('{fl: flushing_n, data: flush_data, cl: cleaned_n});
         if (!rst) begin
            if (prev_req && !prev_ack &&
                (!mem_bus.mem_req_o || mem_bus.mem_addr_o != prev_addr ||
                 mem_bus.mem_we_o != prev_we ||
                 (prev_we && mem_bus.mem_wdata_o != prev_wdata)))
               stab_err++;
            if (prev_ack && prev_we &&
                (!mem_bus.mem_req_o || mem_bus.mem_we_o || mem_bus.mem_addr_o != prev_addr))
               stab_err++;
         end
         prev_req   = mem_bus.mem_req_o;
         prev_we    = mem_bus.mem_we_o;
         prev_addr  = mem_bus.mem_addr_o;
         prev_wdata = mem_bus.mem_wdata_o;
         if (mem_bus.mem_req_o && wait_cnt == ack_delay) begin
            mem_bus.mem_ack_i   = 1'b1;
            mem_bus.mem_rdata_i = rd_pattern(mem_bus.mem_addr_o);
            if (mem_bus.mem_we_o)
               wq.push_back('{we: 1'b1, addr: mem_bus.mem_addr_o, data: mem_bus.mem_wdata_o});
            else
               rq.push_back('{we: 1'b0, addr: mem_bus.mem_addr_o, data: '0});
            wait_cnt = 0;
         end else begin
            mem_bus.mem_ack_i   = 1'b0;
            mem_bus.mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
            if (mem_bus.mem_req_o) wait_cnt++;
            else wait_cnt = 0;
         end
         prev_ack = mem_bus.mem_ack_i;
      end
   end

   // One full refill; cycles = edges from the start-sampling edge to done_o
   task automatic run_refill(input string tag, input logic [7:0] d, input logic [31:0] b,
                             input int dly, output int cycles);
      wq.delete(); rq.delete(); fq.delete();
      dirty     = d;
      ack_delay = dly;
      @(negedge clk);
      start     = 1'b1;
      base_addr = b;
      @(posedge clk); #1;
      start  = 1'b0;
      cycles = 0;
      @(posedge clk); #1;
      cycles = 1;
      check({tag, " busy"}, busy, 1);
      while (done !== 1'b1 && cycles < 1000) begin
         @(posedge clk); #1;
         cycles++;
      end
      check({tag, " done"}, done, 1);
      check({tag, " busy at done"}, busy, 0);
      @(posedge clk); #1;
      check({tag, " done one cycle"}, done, 0);
   endtask

   initial begin : stim
      int cyc;
      int cnt;
      int dones;
      int busy_seen;
      int w;
      logic [31:0]  bm;
      logic [31:0]  ea;
      logic [7:0]   ef;
      logic [127:0] ew;

      vecs[0] = '{dirty: 8'h00, base: 32'h0000_1000, delay: 0, exp_cycles: 32, exp_writes: 0};
      vecs[1] = '{dirty: 8'h04, base: 32'h0000_1000, delay: 0, exp_cycles: 33, exp_writes: 1};
      vecs[2] = '{dirty: 8'hFF, base: 32'h0000_2000, delay: 0, exp_cycles: 40, exp_writes: 8};
      vecs[3] = '{dirty: 8'h81, base: 32'h0000_0000, delay: 1, exp_cycles: 44, exp_writes: 2};
      vecs[4] = '{dirty: 8'h00, base: 32'hFFFF_FFF0, delay: 0, exp_cycles: 32, exp_writes: 0};
      vecs[5] = '{dirty: 8'h0A, base: 32'h0000_3008, delay: 2, exp_cycles: 54, exp_writes: 2};

      rst = 1'b1; start = 1'b0; base_addr = '0; dirty = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst req", mem_bus.mem_req_o, 0);
      check("rst we", mem_bus.mem_we_o, 0);
      check("rst flushing_n", flushing_n, 8'hFF);
      check("rst cleaned_n", cleaned_n, 1);
      check("rst cache_addr", cache_addr, 0);
      check("rst mem_addr", mem_bus.mem_addr_o, 0);
      check("rst wdata", mem_bus.mem_wdata_o, 0);
      check("rst flush_data", flush_data, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         string t;
         t = $sformatf("v%0d", i);
         run_refill(t, vecs[i].dirty, vecs[i].base, vecs[i].delay, cyc);
         bm = vecs[i].base & 32'hFFFF_FFF0;
         check({t, " cycles"}, cyc, vecs[i].exp_cycles);
         check({t, " reads"}, rq.size(), 8);
         check({t, " writes"}, wq.size(), vecs[i].exp_writes);
         check({t, " updates"}, fq.size(), 8);
         for (int k = 0; k < 8 && k < rq.size(); k++) begin
            ea = bm + 32'(16 * k);
            check($sformatf("%s rd_addr%0d", t, k), rq[k].addr, ea);
         end
         for (int k = 0; k < 8 && k < fq.size(); k++) begin
            ea = bm + 32'(16 * k);
            ef = ~(8'h01 << k);
            check($sformatf("%s flushing_n%0d", t, k), fq[k].fl, ef);
            check($sformatf("%s flush_data%0d", t, k), fq[k].data, rd_pattern(ea));
            check($sformatf("%s cleaned_n%0d", t, k), fq[k].cl, 0);
         end
         w = 0;
         for (int q = 0; q < 8; q++) begin
            if (vecs[i].dirty[q] && w < wq.size()) begin
               ea = bm + 32'(16 * q);
               ew = {cword(q, 3), cword(q, 2), cword(q, 1), cword(q, 0)};
               check($sformatf("%s wr_addr%0d", t, q), wq[w].addr, ea);
               check($sformatf("%s wr_data%0d", t, q), wq[w].data, ew);
               w++;
            end
         end
      end

      // Qword 2 dirty with literal expected write-back
      run_refill("dirty2", 8'h04, 32'h0000_1000, 0, cyc);
      check("dirty2 cycles", cyc, 33);
      check("dirty2 nwr", wq.size(), 1);
      if (wq.size() > 0) begin
         check("dirty2 wr_addr", wq[0].addr, 32'h0000_1020);
         check("dirty2 wr_data", wq[0].data, 128'h00000044_00000033_00000022_00000011);
      end
      if (rq.size() > 2) check("dirty2 rd_addr", rq[2].addr, 32'h0000_1020);

      // Slow memory: request must stay frozen while waiting
      run_refill("slow", 8'h24, 32'h0000_7000, 3, cyc);
      check("slow cycles", cyc, 6 * 7 + 2 * 11);
      check("handshake stable", stab_err, 0);

      // Wrap-around of the qword address
      run_refill("wrap", 8'h00, 32'hFFFF_FFF0, 0, cyc);
      if (rq.size() > 1) check("wrap qword1 addr", rq[1].addr, 32'h0000_0000);
      else check("wrap reads", rq.size(), 8);

      // start while busy and in the DONE cycle are both ignored
      wq.delete(); rq.delete(); fq.delete();
      dirty = 8'h00; ack_delay = 0;
      @(negedge clk);
      start = 1'b1; base_addr = 32'h0000_4000;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      start = 1'b1; base_addr = 32'h0000_9000;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 0; dones = 0; busy_seen = 0;
      while (done !== 1'b1 && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("ign done reached", done, 1);
      if (done === 1'b1) dones++;
      start = 1'b1; base_addr = 32'h0000_9000;
      @(posedge clk); #1;
      start = 1'b0;
      check("ign idle busy", busy, 0);
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
         if (busy !== 1'b0) busy_seen++;
      end
      check("ign done count", dones, 1);
      check("ign no restart", busy_seen, 0);
      check("ign reads", rq.size(), 8);
      if (rq.size() > 0) check("ign base", rq[0].addr, 32'h0000_4000);

      // Reset while in write-back
      wq.delete(); rq.delete(); fq.delete();
      dirty = 8'h01; ack_delay = 5;
      @(negedge clk);
      start = 1'b1; base_addr = 32'h0000_6000;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 0;
      while (!(mem_bus.mem_req_o === 1'b1 && mem_bus.mem_we_o === 1'b1) && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("rstwb in wb", {mem_bus.mem_req_o, mem_bus.mem_we_o}, 2'b11);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstwb req", mem_bus.mem_req_o, 0);
      check("rstwb flushing_n", flushing_n, 8'hFF);
      check("rstwb busy", busy, 0);
      check("rstwb done", done, 0);
      rst = 1'b0;
      check("rstwb no update", fq.size(), 0);
      run_refill("after_rst", 8'h00, 32'h0000_5000, 0, cyc);
      check("after_rst cycles", cyc, 32);
      check("after_rst reads", rq.size(), 8);
      if (rq.size() > 0) check("after_rst addr0", rq[0].addr, 32'h0000_5000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
